// File: rtl/pipeline_window_acc.sv
// Windowed accumulator for the add/and/add pipeline result stream.
// Sums WIN accepted beats (or fewer on flush) and presents each sum through a valid/ready handshake.
module pipeline_window_acc #(
   parameter int WIDTH = 32,
   parameter int WIN   = 4,
   parameter int CNT_W = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             flush,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_carry,
   output logic [CNT_W-1:0] out_count,
   output logic             out_valid,
   input  logic             out_ready
);

   localparam logic [0:0] ST_ACC  = 1'b0;
   localparam logic [0:0] ST_HOLD = 1'b1;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(WIN - 1);

   logic [0:0]       r_state;
   logic [WIDTH-1:0] r_acc;
   logic             r_carryAcc;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_outSum;
   logic             r_outCarry;
   logic [CNT_W-1:0] r_outCount;
   logic             r_outValid;

   logic             w_accept;
   logic [WIDTH:0]   w_sum;
   logic [WIDTH-1:0] w_nextAcc;
   logic             w_nextCarry;
   logic [CNT_W-1:0] w_nextCnt;
   logic             w_close;

   // in_ready depends on state alone so the producer never sees a loop through flush or out_ready.
   assign in_ready = (r_state == ST_ACC);
   assign w_accept = in_valid && in_ready;

   always_comb begin
      w_sum       = {1'b0, r_acc} + {1'b0, in_data};
      w_nextAcc   = r_acc;
      w_nextCarry = r_carryAcc;
      w_nextCnt   = r_cnt;
      if (w_accept) begin
         w_nextAcc   = w_sum[WIDTH-1:0];
         w_nextCarry = r_carryAcc | w_sum[WIDTH];
         w_nextCnt   = r_cnt + CNT_W'(1);
      end
      w_close = (r_state == ST_ACC) &&
                ((w_accept && (r_cnt == LAST_BEAT)) ||
                 (flush && ((r_cnt != '0) || w_accept)));
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state    <= ST_ACC;
         r_acc      <= '0;
         r_carryAcc <= 1'b0;
         r_cnt      <= '0;
         r_outSum   <= '0;
         r_outCarry <= 1'b0;
         r_outCount <= '0;
         r_outValid <= 1'b0;
      end else begin
         case (r_state)
            ST_ACC: begin
               if (w_close) begin
                  r_outSum   <= w_nextAcc;
                  r_outCarry <= w_nextCarry;
                  r_outCount <= w_nextCnt;
                  r_outValid <= 1'b1;
                  r_state    <= ST_HOLD;
                  r_acc      <= '0;
                  r_carryAcc <= 1'b0;
                  r_cnt      <= '0;
               end else begin
                  r_acc      <= w_nextAcc;
                  r_carryAcc <= w_nextCarry;
                  r_cnt      <= w_nextCnt;
               end
            end
            default: begin
               // The handshake cycle itself accepts nothing, giving one bubble per window.
               if (out_ready) begin
                  r_outValid <= 1'b0;
                  r_state    <= ST_ACC;
               end
            end
         endcase
      end
   end

   assign out_sum   = r_outSum;
   assign out_carry = r_outCarry;
   assign out_count = r_outCount;
   assign out_valid = r_outValid;

endmodule

// File: tb/tb_pipeline_window_acc.sv
// Table-driven bench for pipeline_window_acc with WIDTH=32, WIN=4, plus hand-written corner sequences.
module tb_pipeline_window_acc;

   logic        clock;
   logic        reset;
   logic [31:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic        flush;
   logic [31:0] out_sum;
   logic        out_carry;
   logic [7:0]  out_count;
   logic        out_valid;
   logic        out_ready;

   int assertCount = 0;
   int failCount   = 0;

   pipeline_window_acc #(.WIDTH(32), .WIN(4), .CNT_W(8)) dut (
      .clock     (clock),
      .reset     (reset),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .flush     (flush),
      .out_sum   (out_sum),
      .out_carry (out_carry),
      .out_count (out_count),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic        rst;
      logic        valid;
      logic [31:0] data;
      logic        fl;
      logic        oRdy;
      logic        expReady;
      logic        expValid;
      logic [31:0] expSum;
      logic        expCarry;
      logic [7:0]  expCount;
      logic        chkAll;
   } vec_t;

   vec_t vecs[$];

   task automatic addVec(input logic rst, input logic valid, input logic [31:0] data,
                         input logic fl, input logic oRdy, input logic expReady,
                         input logic expValid, input logic [31:0] expSum,
                         input logic expCarry, input logic [7:0] expCount,
                         input logic chkAll);
      vec_t v;
      v.rst = rst; v.valid = valid; v.data = data; v.fl = fl; v.oRdy = oRdy;
      v.expReady = expReady; v.expValid = expValid; v.expSum = expSum;
      v.expCarry = expCarry; v.expCount = expCount; v.chkAll = chkAll;
      vecs.push_back(v);
   endtask

   task automatic cmp(input string name, input logic [31:0] actual, input logic [31:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
      end
   endtask

   // Drive one cycle of inputs, then sample #1 after the rising edge.
   task automatic applyStimulus(input logic rst, input logic valid, input logic [31:0] data,
                                input logic fl, input logic oRdy);
      reset     = rst;
      in_valid  = valid;
      in_data   = data;
      flush     = fl;
      out_ready = oRdy;
      @(posedge clock);
      #1;
   endtask

   task automatic checkOutput(input string tag, input vec_t v);
      cmp({tag, ".in_ready"}, 32'(in_ready), 32'(v.expReady));
      cmp({tag, ".out_valid"}, 32'(out_valid), 32'(v.expValid));
      if (v.expValid || v.chkAll) begin
         cmp({tag, ".out_sum"}, out_sum, v.expSum);
         cmp({tag, ".out_carry"}, 32'(out_carry), 32'(v.expCarry));
         cmp({tag, ".out_count"}, 32'(out_count), 32'(v.expCount));
      end
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b0;

      //      rst v  data          f  ordy  rdy vld sum           c  cnt  all
      addVec(1, 0, 32'd0,        0, 0,    1,  0,  32'd0,        0, 8'd0, 1);
      // basic window 1,2,3,4
      addVec(0, 1, 32'd1,        0, 1,    1,  0,  32'd0,        0, 8'd0, 0);
      addVec(0, 1, 32'd2,        0, 1,    1,  0,  32'd0,        0, 8'd0, 0);
      addVec(0, 1, 32'd3,        0, 1,    1,  0,  32'd0,        0, 8'd0, 0);
      addVec(0, 1, 32'd4,        0, 1,    0,  1,  32'd10,       0, 8'd4, 0);
      addVec(0, 0, 32'd0,        0, 1,    1,  0,  32'd10,       0, 8'd4, 1);
      // carry-out window
      addVec(0, 1, 32'hFFFFFFFF, 0, 1,    1,  0,  32'd0,        0, 8'd0, 0);
      addVec(0, 1, 32'd2,        0, 1,    1,  0,  32'd0,        0, 8'd0, 0);
      addVec(0, 1, 32'd0,        0, 1,    1,  0,  32'd0,        0, 8'd0, 0);
      addVec(0, 1, 32'd0,        0, 1,    0,  1,  32'd1,        1, 8'd4, 0);
      addVec(0, 0, 32'd0,        0, 1,    1,  0,  32'd0,        0, 8'd0, 0);
      // early flush with no beat, then an empty flush
      addVec(0, 1, 32'd5,        0, 1,    1,  0,  32'd0,        0, 8'd0, 0);
      addVec(0, 1, 32'd7,        0, 1,    1,  0,  32'd0,        0, 8'd0, 0);
      addVec(0, 0, 32'd0,        1, 1,    0,  1,  32'd12,       0, 8'd2, 0);
      addVec(0, 0, 32'd0,        0, 1,    1,  0,  32'd0,        0, 8'd0, 0);
      addVec(0, 0, 32'd0,        1, 1,    1,  0,  32'd12,       0, 8'd2, 1);
      addVec(0, 0, 32'd0,        1, 1,    1,  0,  32'd12,       0, 8'd2, 1);
      // last beat coincides with flush
      addVec(0, 1, 32'd1,        0, 1,    1,  0,  32'd0,        0, 8'd0, 0);
      addVec(0, 1, 32'd1,        0, 1,    1,  0,  32'd0,        0, 8'd0, 0);
      addVec(0, 1, 32'd1,        0, 1,    1,  0,  32'd0,        0, 8'd0, 0);
      addVec(0, 1, 32'd1,        1, 1,    0,  1,  32'd4,        0, 8'd4, 0);
      addVec(0, 0, 32'd0,        0, 1,    1,  0,  32'd0,        0, 8'd0, 0);
      // backpressure: result held, offered beats (and a flush) ignored
      addVec(0, 1, 32'd10,       0, 0,    1,  0,  32'd0,        0, 8'd0, 0);
      addVec(0, 1, 32'd20,       0, 0,    1,  0,  32'd0,        0, 8'd0, 0);
      addVec(0, 1, 32'd30,       0, 0,    1,  0,  32'd0,        0, 8'd0, 0);
      addVec(0, 1, 32'd40,       0, 0,    0,  1,  32'd100,      0, 8'd4, 0);
      for (int i = 0; i < 5; i++)
         addVec(0, 1, 32'd99,    (i == 2), 0, 0, 1, 32'd100,    0, 8'd4, 0);
      addVec(0, 1, 32'd99,       0, 1,    1,  0,  32'd0,        0, 8'd0, 0);
      addVec(0, 1, 32'd1,        0, 1,    1,  0,  32'd0,        0, 8'd0, 0);
      addVec(0, 1, 32'd2,        0, 1,    1,  0,  32'd0,        0, 8'd0, 0);
      addVec(0, 1, 32'd3,        0, 1,    1,  0,  32'd0,        0, 8'd0, 0);
      addVec(0, 1, 32'd4,        0, 1,    0,  1,  32'd10,       0, 8'd4, 0);
      addVec(0, 0, 32'd0,        0, 1,    1,  0,  32'd0,        0, 8'd0, 0);
      // reset mid-window discards the partial sum
      addVec(0, 1, 32'd9,        0, 1,    1,  0,  32'd0,        0, 8'd0, 0);
      addVec(0, 1, 32'd9,        0, 1,    1,  0,  32'd0,        0, 8'd0, 0);
      addVec(1, 1, 32'd9,        0, 1,    1,  0,  32'd0,        0, 8'd0, 1);
      addVec(0, 1, 32'd1,        0, 1,    1,  0,  32'd0,        0, 8'd0, 1);
      addVec(0, 1, 32'd2,        0, 1,    1,  0,  32'd0,        0, 8'd0, 1);
      addVec(0, 1, 32'd3,        0, 1,    1,  0,  32'd0,        0, 8'd0, 1);
      addVec(0, 1, 32'd4,        0, 1,    0,  1,  32'd10,       0, 8'd4, 0);
      addVec(0, 0, 32'd0,        0, 1,    1,  0,  32'd0,        0, 8'd0, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].rst, vecs[i].valid, vecs[i].data, vecs[i].fl, vecs[i].oRdy);
         checkOutput($sformatf("vec%0d", i), vecs[i]);
      end

      // Hand sequence: feed 7,7,7,7 with out_ready low, wait (bounded) for the result.
      begin
         bit seen = 0;
         for (int i = 0; i < 4; i++) applyStimulus(0, 1, 32'd7, 0, 0);
         applyStimulus(0, 0, 32'd0, 0, 0);
         for (int i = 0; i < 8 && !seen; i++) begin
            if (out_valid) seen = 1;
            else applyStimulus(0, 0, 32'd0, 0, 0);
         end
         cmp("seq.wait_valid", 32'(seen), 32'd1);
         cmp("seq.held_sum", out_sum, 32'd28);
         cmp("seq.held_count", 32'(out_count), 32'd4);
      end

      // Hand sequence: reset while a result is pending drops it.
      applyStimulus(1, 0, 32'd0, 0, 0);
      cmp("seq.rst_valid", 32'(out_valid), 32'd0);
      cmp("seq.rst_sum", out_sum, 32'd0);
      cmp("seq.rst_count", 32'(out_count), 32'd0);
      cmp("seq.rst_ready", 32'(in_ready), 32'd1);

      // Hand sequence: single beat then flush closes a one-beat window.
      applyStimulus(0, 1, 32'd55, 0, 1);
      applyStimulus(0, 0, 32'd0, 1, 1);
      cmp("seq.one_valid", 32'(out_valid), 32'd1);
      cmp("seq.one_sum", out_sum, 32'd55);
      cmp("seq.one_count", 32'(out_count), 32'd1);
      applyStimulus(0, 0, 32'd0, 0, 1);
      cmp("seq.one_drain", 32'(out_valid), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
